hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller for the five-stage LEGv8 datapath, acting as the consumer-side counterpart of the ID/EX pipeline register. It watches what ID/EX is presenting to EX and what IF/ID is presenting to decode. It then drives the write-enables, bubble and flush controls of the PC, IF/ID, ID/EX and EX/MEM registers. Two hazards are handled: load-use, which stalls for a programmable number of cycles, and taken branch resolved in MEM, which flushes the three younger stages. Saturating event counters are kept for performance debug.

## Interface
- LOAD_STALL_CYCLES, 1, stall cycles per load-use hazard; legal range 1..7.
- CNT_W, 16, width of the event counters.

Ports:
- CLOCK  in  1  single clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- idex_memRead  in  1  memRead output of ID/EX; the instruction now in EX is a load.
- idex_write_reg  in  5  destination register of the instruction in EX.
- ifid_valid  in  1  IF/ID holds a real instruction.
- ifid_rn  in  5  first source register of the instruction in decode.
- ifid_rm  in  5  second source register of the instruction in decode.
- ifid_uses_rm  in  1  decode instruction reads rm (R-format, CBZ/STUR data).
- branch_taken  in  1  isBranch & zero from MEM; branch target is on the PC mux this cycle.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID load enable.
- idex_bubble  out  1  ID/EX loads zeros into all control fields this edge.
- ifid_flush / idex_flush / exmem_flush  out  1 each  clear the control and valid fields of that register this edge.
- stall_active  out  1  a stall is being applied this cycle.
- stall_count  out  CNT_W  saturating count of stalled cycles.
- flush_count  out  CNT_W  saturating count of branch flushes.

## Operation
- Hazard term: `hz = ifid_valid & idex_memRead & (idex_write_reg != 31) & ((ifid_rn == idex_write_reg) | (ifid_uses_rm & (ifid_rm == idex_write_reg)))`. Register X31 (XZR) never creates a hazard.
- FSM states:
  - **RUN**: no stall in progress.
  - **STALL**: an extended stall is in progress, with a 3-bit `stall_left` counter.
- **Stall cycle** outputs: pc_write=0, ifid_write=0, idex_bubble=1, stall_active=1.
- **RUN**:
  - If branch_taken: flush cycle.
  - Else if hz: stall cycle. If LOAD_STALL_CYCLES>1, go to STALL with stall_left=LOAD_STALL_CYCLES-1; otherwise stay in RUN.
  - Otherwise: pc_write=1, ifid_write=1, all other controls 0.
- **STALL**:
  - Without branch_taken: stall cycle regardless of hz, and stall_left decrements. When stall_left==1 during this cycle, the next state is RUN.
- **Flush cycle** (branch_taken=1, any state):
  - ifid_flush=idex_flush=exmem_flush=1, pc_write=1, ifid_write=1, idex_bubble=0, stall_active=0.
  - Next state is RUN and stall_left is cleared. A branch always aborts a stall in progress.
- Priority: branch_taken > STALL continuation > hz.
- Counters:
  - stall_count increments on every cycle with stall_active=1.
  - flush_count increments on every cycle with branch_taken=1.
  - Both saturate at all-ones and never wrap.

## Timing
- All pipeline controls are combinational from the current state and inputs. They apply at the next rising CLOCK edge, so a stall has zero cycles of detection latency.
- One load-use hazard costs exactly LOAD_STALL_CYCLES cycles of pc_write=0.
- The bubble enters ID/EX on the first stalled edge. From then on idex_memRead=0, so hz deasserts naturally after the first cycle. STALL does not depend on hz.
- A flush takes exactly one cycle and carries no residual penalty.
- Reset:
  - RESET high forces state=RUN, stall_left=0, stall_count=0 and flush_count=0 immediately, without waiting for a clock edge.
  - While RESET is high, outputs are forced to pc_write=1, ifid_write=1 and all others 0, regardless of inputs.
  - A reset asserted mid-stall abandons the stall.
  - The first edge after deassertion evaluates normally.

## Test plan
- **Load-use on rn, N=1:** idex_memRead=1, idex_write_reg=5, ifid_rn=5, ifid_valid=1 -> one cycle of pc_write=0, ifid_write=0, idex_bubble=1; next cycle (idex_memRead=0) pc_write=1; stall_count=1.
- **No false hazard:**
  - idex_write_reg=31 and ifid_rn=31 -> no stall.
  - ifid_rm=7 matching, ifid_uses_rm=0 -> no stall.
  - ifid_valid=0 with a match -> no stall.
- **Extended stall, LOAD_STALL_CYCLES=3:** hazard on rm with ifid_uses_rm=1 -> pc_write=0 for exactly 3 consecutive cycles even though hz drops after cycle 1; stall_count=3; state returns to RUN.
- **Branch aborts stall, N=3:** branch_taken=1 in the 2nd stall cycle -> all three flushes=1 and pc_write=1 that cycle; the next cycle is normal run; stall_count=1 before the flush cycle and stays 1 after it; flush_count=1.
- **Simultaneous hazard and branch in RUN:** hz=1 and branch_taken=1 -> flush wins, idex_bubble=0, stall_count unchanged.
- **Saturation and reset:**
  - With CNT_W=4, 20 stalled cycles -> stall_count holds at 15.
  - RESET asserted mid-STALL between edges -> counters read 0 and pc_write=1 immediately.

Source files
------------

// File: rtl/hazard_unit.sv
// Hazard controller for the five-stage LEGv8 pipeline.
// Detects load-use hazards between EX and decode and stalls the front end
// for a programmable number of cycles. Flushes the three younger stages
// when a branch taken in MEM redirects the PC. Keeps saturating event
// counters for stalled cycles and branch flushes.
module hazard_unit #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             idex_memRead,
  input  logic [4:0]       idex_write_reg,
  input  logic             ifid_valid,
  input  logic [4:0]       ifid_rn,
  input  logic [4:0]       ifid_rm,
  input  logic             ifid_uses_rm,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             stall_active,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  // Cycles still owed after the first stalled cycle of a load-use hazard.
  localparam logic [2:0]       STALL_INIT = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [2:0]       stall_left_q, stall_left_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;
  logic             hz;

  // Load-use hazard: the load in EX writes a register that decode reads.
  // XZR (X31) is never a real destination, so it never creates a hazard.
  always_comb begin
    hz = ifid_valid & idex_memRead & (idex_write_reg != 5'd31) &
         ((ifid_rn == idex_write_reg) |
          (ifid_uses_rm & (ifid_rm == idex_write_reg)));
  end

  // Next-state and pipeline controls: branch beats stall continuation beats hz.
  always_comb begin
    state_d      = state_q;
    stall_left_d = stall_left_q;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_bubble  = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    stall_active = 1'b0;
    if (RESET) begin
      // Outputs stay at the plain-run defaults while reset is held.
      state_d      = RUN;
      stall_left_d = 3'd0;
    end else if (branch_taken) begin
      // Flush cycle; a branch always aborts a stall in progress.
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      exmem_flush  = 1'b1;
      state_d      = RUN;
      stall_left_d = 3'd0;
    end else if (state_q == STALL) begin
      // Continue the extended stall independent of hz, which has dropped.
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_bubble  = 1'b1;
      stall_active = 1'b1;
      stall_left_d = stall_left_q - 3'd1;
      if (stall_left_q == 3'd1) begin
        state_d = RUN;
      end
    end else if (hz) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_bubble  = 1'b1;
      stall_active = 1'b1;
      if (LOAD_STALL_CYCLES > 1) begin
        state_d      = STALL;
        stall_left_d = STALL_INIT;
      end
    end
  end

  // Saturating event counters; they hold at all-ones rather than wrap.
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (stall_active && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + CNT_ONE;
    end
    if (!RESET && branch_taken && (flush_count_q != CNT_MAX)) begin
      flush_count_d = flush_count_q + CNT_ONE;
    end
  end

  // State and counter registers, cleared asynchronously by RESET.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q       <= RUN;
      stall_left_q  <= 3'd0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      stall_left_q  <= stall_left_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit. Two instances share the same inputs:
// one with a single-cycle stall and 16-bit counters, one with a 3-cycle
// stall and 4-bit counters so saturation is reachable quickly.
module tb_hazard_unit;

  localparam int N_A = 1;
  localparam int W_A = 16;
  localparam int N_B = 3;
  localparam int W_B = 4;
  localparam int MAX_A = (1 << W_A) - 1;
  localparam int MAX_B = (1 << W_B) - 1;

  // Control vector order: pc_write, ifid_write, idex_bubble,
  // ifid_flush, idex_flush, exmem_flush, stall_active.
  localparam logic [6:0] C_RUN   = 7'b1100000;
  localparam logic [6:0] C_STALL = 7'b0010001;
  localparam logic [6:0] C_FLUSH = 7'b1101110;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       idex_memRead = 1'b0;
  logic [4:0] idex_write_reg = 5'd0;
  logic       ifid_valid = 1'b0;
  logic [4:0] ifid_rn = 5'd0;
  logic [4:0] ifid_rm = 5'd0;
  logic       ifid_uses_rm = 1'b0;
  logic       branch_taken = 1'b0;

  logic pc_write_a, ifid_write_a, idex_bubble_a, ifid_flush_a, idex_flush_a, exmem_flush_a, stall_active_a;
  logic pc_write_b, ifid_write_b, idex_bubble_b, ifid_flush_b, idex_flush_b, exmem_flush_b, stall_active_b;
  logic [W_A-1:0] stall_count_a, flush_count_a;
  logic [W_B-1:0] stall_count_b, flush_count_b;

  hazard_unit #(.LOAD_STALL_CYCLES(N_A), .CNT_W(W_A)) dut_a (
    .CLOCK(CLOCK), .RESET(RESET),
    .idex_memRead(idex_memRead), .idex_write_reg(idex_write_reg),
    .ifid_valid(ifid_valid), .ifid_rn(ifid_rn), .ifid_rm(ifid_rm),
    .ifid_uses_rm(ifid_uses_rm), .branch_taken(branch_taken),
    .pc_write(pc_write_a), .ifid_write(ifid_write_a), .idex_bubble(idex_bubble_a),
    .ifid_flush(ifid_flush_a), .idex_flush(idex_flush_a), .exmem_flush(exmem_flush_a),
    .stall_active(stall_active_a), .stall_count(stall_count_a), .flush_count(flush_count_a)
  );

  hazard_unit #(.LOAD_STALL_CYCLES(N_B), .CNT_W(W_B)) dut_b (
    .CLOCK(CLOCK), .RESET(RESET),
    .idex_memRead(idex_memRead), .idex_write_reg(idex_write_reg),
    .ifid_valid(ifid_valid), .ifid_rn(ifid_rn), .ifid_rm(ifid_rm),
    .ifid_uses_rm(ifid_uses_rm), .branch_taken(branch_taken),
    .pc_write(pc_write_b), .ifid_write(ifid_write_b), .idex_bubble(idex_bubble_b),
    .ifid_flush(ifid_flush_b), .idex_flush(idex_flush_b), .exmem_flush(exmem_flush_b),
    .stall_active(stall_active_b), .stall_count(stall_count_b), .flush_count(flush_count_b)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [6:0] ctl_a;
    logic [6:0] ctl_b;
    int         sc_a;
    int         fc_a;
    int         sc_b;
    int         fc_b;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done = 0;

  // Reference model: stall cycles still owed, plus event counts.
  int rem_a = 0, rem_b = 0;
  int sc_a = 0, fc_a = 0, sc_b = 0, fc_b = 0;

  function automatic bit model_hz();
    return ifid_valid && idex_memRead && (idex_write_reg != 5'd31) &&
           ((ifid_rn == idex_write_reg) || (ifid_uses_rm && (ifid_rm == idex_write_reg)));
  endfunction

  function automatic logic [6:0] model_ctl(input int rem);
    if (RESET) return C_RUN;
    if (branch_taken) return C_FLUSH;
    if (rem > 0 || model_hz()) return C_STALL;
    return C_RUN;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Apply one cycle of inputs after the edge, record the expected response,
  // then advance the model to the state it must hold after the next edge.
  task automatic cyc(input bit rst, input bit mr, input logic [4:0] wr, input bit v,
                     input logic [4:0] rn, input logic [4:0] rm, input bit um, input bit br);
    exp_t e;
    bit   h;
    @(posedge CLOCK);
    #2;
    RESET = rst; idex_memRead = mr; idex_write_reg = wr; ifid_valid = v;
    ifid_rn = rn; ifid_rm = rm; ifid_uses_rm = um; branch_taken = br;
    #1;
    if (rst) begin
      rem_a = 0; rem_b = 0; sc_a = 0; fc_a = 0; sc_b = 0; fc_b = 0;
    end
    h = model_hz();
    e.ctl_a = model_ctl(rem_a);
    e.ctl_b = model_ctl(rem_b);
    e.sc_a = sc_a; e.fc_a = fc_a; e.sc_b = sc_b; e.fc_b = fc_b;
    exp_q.push_back(e);
    if (!rst) begin
      if (br) begin
        rem_a = 0; rem_b = 0;
        if (fc_a < MAX_A) fc_a++;
        if (fc_b < MAX_B) fc_b++;
      end else begin
        if (rem_a > 0) rem_a--; else if (h) rem_a = N_A - 1;
        if (rem_b > 0) rem_b--; else if (h) rem_b = N_B - 1;
        if (e.ctl_a[0] && sc_a < MAX_A) sc_a++;
        if (e.ctl_b[0] && sc_b < MAX_B) sc_b++;
      end
    end
  endtask

  task automatic idle();
    cyc(0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0);
  endtask

  // Monitor: the DUT presents a decision every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLOCK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ctl_a", {pc_write_a, ifid_write_a, idex_bubble_a, ifid_flush_a,
                        idex_flush_a, exmem_flush_a, stall_active_a}, e.ctl_a);
        check("ctl_b", {pc_write_b, ifid_write_b, idex_bubble_b, ifid_flush_b,
                        idex_flush_b, exmem_flush_b, stall_active_b}, e.ctl_b);
        check("stall_count_a", stall_count_a, e.sc_a);
        check("flush_count_a", flush_count_a, e.fc_a);
        check("stall_count_b", stall_count_b, e.sc_b);
        check("flush_count_b", flush_count_b, e.fc_b);
      end
    end
  end

  initial begin
    int wait_cycles;
    // Reset state.
    cyc(1, 1, 5'd5, 1, 5'd5, 5'd0, 0, 1);
    cyc(1, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0);
    idle();
    // Load-use on rn, then the bubble clears memRead.
    cyc(0, 1, 5'd5, 1, 5'd5, 5'd9, 0, 0);
    idle(); idle(); idle();
    // No false hazards: XZR, rm match without use, invalid decode slot.
    cyc(0, 1, 5'd31, 1, 5'd31, 5'd31, 1, 0);
    cyc(0, 1, 5'd7, 1, 5'd3, 5'd7, 0, 0);
    cyc(0, 1, 5'd5, 0, 5'd5, 5'd5, 1, 0);
    // Extended stall on rm with uses_rm.
    cyc(0, 1, 5'd7, 1, 5'd3, 5'd7, 1, 0);
    idle(); idle(); idle(); idle();
    // Branch aborts a stall in its second cycle.
    cyc(0, 1, 5'd9, 1, 5'd9, 5'd0, 0, 0);
    cyc(0, 0, 5'd0, 1, 5'd9, 5'd0, 0, 1);
    idle(); idle();
    // Hazard and branch together in RUN: flush wins.
    cyc(0, 1, 5'd4, 1, 5'd4, 5'd4, 1, 1);
    idle();
    // Saturation: 20 held-hazard cycles drive the 4-bit counter to 15.
    for (int i = 0; i < 20; i++) cyc(0, 1, 5'd2, 1, 5'd2, 5'd0, 0, 0);
    #3;
    check("stall_count_b_sat", stall_count_b, 15);
    // Reset asserted mid-stall, between edges.
    cyc(0, 1, 5'd6, 1, 5'd6, 5'd0, 0, 0);
    cyc(1, 0, 5'd0, 1, 5'd6, 5'd0, 0, 0);
    #1;
    check("reset_pc_write_b", pc_write_b, 1);
    check("reset_stall_count_b", stall_count_b, 0);
    idle(); idle();
    // Randomized traffic biased toward register matches.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] pick[4];
      pick[0] = 5'd5; pick[1] = 5'd31; pick[2] = 5'd7; pick[3] = 5'($urandom_range(0, 31));
      cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 60),
          pick[$urandom_range(0, 3)], ($urandom_range(0, 99) < 85),
          pick[$urandom_range(0, 3)], pick[$urandom_range(0, 3)],
          $urandom_range(0, 1), ($urandom_range(0, 99) < 10));
    end
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge CLOCK);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
